// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package conversor_bcd_pkg;

  localparam int unsigned ANCHO_DEF   = 16;
  localparam int unsigned DIGITOS_DEF = 5;
  localparam int unsigned CORRECCION  = 3;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

endpackage

// File: rtl/corrector_bcd.sv
// Per-digit double-dabble correction: digits of 5 or more get 3 added before the shift.
module corrector_bcd
  import conversor_bcd_pkg::*;
(
  input  logic [3:0] digito,
  output logic [3:0] digito_c
);

  always_comb begin
    digito_c = digito;
    if (digito >= 4'd5) begin
      digito_c = digito + 4'(CORRECCION);
    end
  end

endmodule

// File: rtl/conversor_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter with leading-zero blank mask.
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter int unsigned ANCHO   = ANCHO_DEF,
  parameter int unsigned DIGITOS = DIGITOS_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ANCHO-1:0]       numero,
  input  logic                   cargar,
  output logic                   ocupado,
  output logic                   listo,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic [DIGITOS-1:0]     apagar
);

  localparam int unsigned BCD_W = 4 * DIGITOS;
  localparam int unsigned CNT_W = $clog2(ANCHO + 1);
  localparam int unsigned DES_W = BCD_W + ANCHO;
  localparam logic [DIGITOS-1:0] APAGAR_RST = {{(DIGITOS-1){1'b1}}, 1'b0};

  estado_t             state_q, state_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [ANCHO-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_d;
  logic [DIGITOS-1:0]  apagar_d;
  logic                listo_d;
  logic                ocupado_d;

  logic [BCD_W-1:0]    corregido_c;
  logic [DES_W-1:0]    desplazado_c;
  logic [DIGITOS-1:0]  mascara_c;
  logic                cero_c;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
    corrector_bcd u_corr (
      .digito   (scratch_q[4*g +: 4]),
      .digito_c (corregido_c[4*g +: 4])
    );
  end

  // Blank a digit only when it and every more significant digit are zero.
  always_comb begin
    mascara_c = '0;
    cero_c    = 1'b1;
    for (int i = int'(DIGITOS) - 1; i >= 1; i--) begin
      cero_c       = cero_c & (scratch_q[4*i +: 4] == 4'd0);
      mascara_c[i] = cero_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= REPOSO;
      scratch_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      apagar    <= APAGAR_RST;
      listo     <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bcd       <= bcd_d;
      apagar    <= apagar_d;
      listo     <= listo_d;
      ocupado   <= ocupado_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    scratch_d    = scratch_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd;
    apagar_d     = apagar;
    listo_d      = 1'b0;
    desplazado_c = {corregido_c, shift_q} << 1;

    case (state_q)
      REPOSO: begin
        if (cargar) begin
          shift_d   = numero;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = DESPLAZA;
        end
      end
      DESPLAZA: begin
        {scratch_d, shift_d} = desplazado_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ANCHO - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bcd_d    = scratch_q;
        apagar_d = mascara_c;
        listo_d  = 1'b1;
        state_d  = REPOSO;
      end
      default: begin
        state_d = REPOSO;
      end
    endcase

    ocupado_d = (state_d != REPOSO);
  end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 SHALL have parameter ANCHO, default 16, binary input width.
REQ-002 SHALL have parameter DIGITOS, default 5, BCD digit count; SHALL hold 10^DIGITOS > 2^ANCHO-1.
REQ-003 SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port numero  input  ANCHO  binary count from the upstream frequency counter.
REQ-006 SHALL have port cargar  input  1  single-cycle start strobe; wired to the counter's one-second gate delayed one cycle.
REQ-007 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-008 SHALL have port listo  output  1  single-cycle pulse when bcd updates.
REQ-009 SHALL have port bcd  output  4*DIGITOS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-010 SHALL have port apagar  output  DIGITOS  per-digit leading-zero blank mask; 1 = blank that digit.

Function
REQ-011 SHALL implement sequential shift-add-3 (double-dabble) with FSM states REPOSO, DESPLAZA, FIN.
REQ-012 In REPOSO with cargar=1 at edge k: SHALL latch numero into the shift register, clear the BCD scratch register, clear the iteration counter, and enter DESPLAZA.
REQ-013 Each DESPLAZA cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left one bit, in a single clock.
REQ-014 After exactly ANCHO shifts (edges k+1..k+ANCHO), SHALL enter FIN.
REQ-015 At the edge leaving FIN (k+ANCHO+1), SHALL load bcd and apagar, assert listo for exactly one cycle, and return to REPOSO.
REQ-016 Latency: cargar sampled at edge k -> listo high in the cycle following edge k+ANCHO+1 (k+17 for default).
REQ-017 ocupado SHALL equal (state != REPOSO), registered.
REQ-018 cargar while ocupado=1 SHALL be ignored; no queuing.
REQ-019 cargar in the same cycle as listo=1 SHALL be accepted, giving back-to-back conversions.
REQ-020 bcd and apagar SHALL hold their previous values for the whole conversion; they change only with listo.
REQ-021 apagar[i] SHALL be 1 iff digit i and all higher digits are zero, for i >= 1; apagar[0] SHALL always be 0.
REQ-022 numero changes after edge k SHALL NOT affect the conversion in progress.
REQ-023 Iteration counter width SHALL be clog2(ANCHO+1); no wrap is permitted before FIN.

Reset
REQ-024 reset_n low SHALL asynchronously force state REPOSO, ocupado=0, listo=0, bcd=0, apagar = all ones except bit 0, and clear the counter and internal registers.
REQ-025 Reset asserted mid-conversion SHALL abort it with no listo pulse; the first cargar after release SHALL start a clean conversion.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, defaults ANCHO=16 and DIGITOS=5, and the constant CORRECCION=3.
REQ-027 The per-digit correction (>=5 -> +3) SHALL be a combinational sub-module corrector_bcd, instantiated DIGITOS times.

Verification
REQ-028 numero=0, cargar pulse -> listo at cycle +17, bcd=0x00000, apagar=5'b11110.
REQ-029 numero=65535 -> bcd=0x65535, apagar=5'b00000.
REQ-030 numero=1234 -> bcd=0x01234, apagar=5'b10000; numero changed to 9 at cycle +3 -> result unchanged.
REQ-031 cargar pulses at cycles +0 and +5 -> exactly one listo; then cargar during the listo cycle with numero=42 -> second listo 17 cycles later, bcd=0x00042, apagar=5'b11100.
REQ-032 reset_n low at cycle +8 of a conversion of 500 -> no listo, bcd=0, apagar=5'b11110; next conversion of 500 -> bcd=0x00500.
